// File: rtl/dcache_controller_if.sv
// CPU MEM-stage and line-wide memory signals of the data cache, grouped so the
// controller and its environment bind to one bundle.
interface dcache_if;
    logic         p1_req_i;
    logic         p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    // Handshakes: a CPU access is valid while p1_req_i = 1 and completes in the
    // first cycle p1_stall_o = 0 (stall acts as not-ready; p1_* held stable while
    // stalled). A memory request is valid while mem_enable_o = 1, is held
    // constant until the cycle mem_ack_i = 1, and completes in that cycle.
    modport slave (
        input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache with 8-word lines:
// zero-cycle hits, stall-driven write-back and refill on a miss.
module dcache_controller #(
    parameter int NUM_LINES = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    dcache_if.slave    bus,
    output logic [1:0] fsm_state
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [255:0]         data_q [NUM_LINES];

    logic [2:0]       offset;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [7:0]       word_base;
    logic             hit;
    logic             store_hit;
    logic             refill;
    logic             unused_ok;

    assign offset    = bus.p1_addr_i[4:2];
    assign idx       = bus.p1_addr_i[4+IDX_W:5];
    assign req_tag   = bus.p1_addr_i[31:5+IDX_W];
    assign word_base = {offset, 5'b0};
    assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
    assign fsm_state = state_q;
    assign unused_ok = &{1'b0, bus.p1_addr_i[1:0]};

    always_comb begin
        state_d          = state_q;
        store_hit        = 1'b0;
        refill           = 1'b0;
        bus.p1_stall_o   = 1'b0;
        bus.p1_data_o    = 32'd0;
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = 32'd0;
        bus.mem_data_o   = 256'd0;
        case (state_q)
            IDLE: begin
                if (bus.p1_req_i) begin
                    if (hit) begin
                        if (bus.p1_write_i) store_hit = 1'b1;
                        else                bus.p1_data_o = data_q[idx][word_base +: 32];
                    end else begin
                        bus.p1_stall_o = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.p1_stall_o   = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {tag_q[idx], idx, 5'b0};
                bus.mem_data_o   = data_q[idx];
                if (bus.mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                bus.p1_stall_o   = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = {req_tag, idx, 5'b0};
                if (bus.mem_ack_i) begin
                    refill  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                // Dead cycle lets the refilled line settle before IDLE re-evaluates the hit.
                bus.p1_stall_o = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (refill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag/data need no reset; gating with rst_i keeps an aborted refill from landing.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (refill) begin
                data_q[idx] <= bus.mem_data_i;
                tag_q[idx]  <= req_tag;
            end else if (store_hit) begin
                data_q[idx][word_base +: 32] <= bus.p1_data_i;
            end
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a line-level cache/memory model predicts every
// cycle's outputs for directed and random accesses; a compare process checks them.
module tb_dcache_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    dcache_if bus ();

    dcache_controller #(.NUM_LINES(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Model: cache contents per line and a sparse backing memory keyed by line address.
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_data  [32];
    logic [255:0] mem_model [int unsigned];

    // Expected outputs per cycle: {stall, p1_data, mem_en, mem_wr, mem_addr, mem_data}.
    logic [322:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    int           cur_run = 0;
    int           last_run = 0;
    logic [31:0]  last_data = 32'd0;
    int           wb_cycles = 0;
    logic [31:0]  wb_addr = 32'd0;
    logic [255:0] wb_data = 256'd0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [322:0] pack(input logic stall, input logic [31:0] data,
                                          input logic en, input logic wr,
                                          input logic [31:0] addr, input logic [255:0] wd);
        return {stall, data, en, wr, addr, wd};
    endfunction

    function automatic logic [255:0] mem_line(input int unsigned la);
        logic [255:0] l;
        if (mem_model.exists(la)) return mem_model[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = la * 32'h9E37_79B1 + w * 32'h0101_0101 + 32'h5A5A_0000;
        mem_model[la] = l;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [322:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",    {255'd0, bus.p1_stall_o},   {255'd0, e[322]});
            chk("p1_data",  {224'd0, bus.p1_data_o},    {224'd0, e[321:290]});
            chk("mem_en",   {255'd0, bus.mem_enable_o}, {255'd0, e[289]});
            chk("mem_wr",   {255'd0, bus.mem_write_o},  {255'd0, e[288]});
            chk("mem_addr", {224'd0, bus.mem_addr_o},   {224'd0, e[287:256]});
            chk("mem_data", bus.mem_data_o,             e[255:0]);
        end
        if (!rst) begin
            if (bus.p1_stall_o === 1'b1) cur_run++;
            else if (cur_run > 0) begin
                last_run = cur_run;
                cur_run  = 0;
            end
            if (bus.p1_req_i && !bus.p1_write_i && bus.p1_stall_o === 1'b0) last_data = bus.p1_data_o;
            if (bus.mem_enable_o === 1'b1 && bus.mem_write_o === 1'b1) begin
                wb_cycles++;
                wb_addr = bus.mem_addr_o;
                wb_data = bus.mem_data_o;
            end
        end
    end

    task automatic idle();
        bus.p1_req_i   = 1'b0;
        bus.mem_ack_i  = 1'($urandom_range(0, 1));
        bus.mem_data_i = {8{$urandom()}};
        exp_q.push_back(pack(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0));
        tick();
        bus.mem_ack_i = 1'b0;
    endtask

    // One CPU access; lat_wb / lat_al = extra wait cycles before each memory ack.
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             input int lat_wb, input int lat_al);
        int unsigned  idx, off, la, va;
        logic [21:0]  tag;
        logic [255:0] line;
        logic [31:0]  word;
        idx = (a / 32) % 32;
        off = (a / 4) % 8;
        tag = 22'(a / 1024);
        la  = a - (a % 32);
        bus.p1_req_i   = 1'b1;
        bus.p1_write_i = wr;
        bus.p1_addr_i  = a;
        bus.p1_data_i  = d;
        bus.mem_ack_i  = 1'b0;
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            exp_q.push_back(pack(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0));
            tick();
            if (m_dirty[idx]) begin
                va = m_tag[idx] * 1024 + idx * 32;
                for (int k = 0; k <= lat_wb; k++) begin
                    bus.mem_ack_i = (k == lat_wb);
                    exp_q.push_back(pack(1'b1, 32'd0, 1'b1, 1'b1, va, m_data[idx]));
                    tick();
                end
                mem_model[va] = m_data[idx];
            end
            line = mem_line(la);
            bus.mem_data_i = line;
            for (int k = 0; k <= lat_al; k++) begin
                bus.mem_ack_i = (k == lat_al);
                exp_q.push_back(pack(1'b1, 32'd0, 1'b1, 1'b0, la, 256'd0));
                tick();
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            m_data[idx]  = line;
            bus.mem_ack_i  = 1'b0;
            bus.mem_data_i = {8{$urandom()}};
            exp_q.push_back(pack(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0));
            tick();
        end
        word = m_data[idx][off*32 +: 32];
        exp_q.push_back(pack(1'b0, wr ? 32'd0 : word, 1'b0, 1'b0, 32'd0, 256'd0));
        tick();
        if (wr) begin
            m_data[idx][off*32 +: 32] = d;
            m_dirty[idx] = 1'b1;
        end
        bus.p1_req_i = 1'b0;
    endtask

    initial begin
        logic [255:0] seed_line;
        int           wb_before;
        int unsigned  ra;
        rst            = 1'b1;
        bus.p1_req_i   = 1'b0;
        bus.p1_write_i = 1'b0;
        bus.p1_addr_i  = 32'd0;
        bus.p1_data_i  = 32'd0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = 256'd0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        seed_line = mem_line(32'h100);
        seed_line[63:32] = 32'hDEAD_BEEF;
        mem_model[32'h100] = seed_line;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_state",  {254'd0, fsm_state}, 256'd0);
        chk("reset_mem_en", {255'd0, bus.mem_enable_o}, 256'd0);
        idle();

        // Cold load miss: allocate acked on its third cycle.
        do_access(0, 32'h0000_0104, 32'd0, 0, 2);
        chk("cold_stall_len", last_run, 5);
        chk("cold_data", {224'd0, last_data}, {224'd0, 32'hDEAD_BEEF});
        chk("cold_no_wb", wb_cycles, 0);

        do_access(0, 32'h0000_0104, 32'd0, 0, 0);
        do_access(1, 32'h0000_0108, 32'h1234_5678, 0, 0);
        do_access(0, 32'h0000_0108, 32'd0, 0, 0);
        chk("hit_load_after_store", {224'd0, last_data}, {224'd0, 32'h1234_5678});
        chk("hit_no_wb", wb_cycles, 0);

        // Dirty conflict miss at the same index.
        do_access(0, 32'h0000_0504, 32'd0, 1, 1);
        chk("dirty_wb_addr", {224'd0, wb_addr}, {224'd0, 32'h0000_0100});
        chk("dirty_wb_word", {224'd0, wb_data[95:64]}, {224'd0, 32'h1234_5678});
        chk("dirty_wb_cycles", wb_cycles, 2);
        chk("dirty_stall_len", last_run, 6);

        // Clean conflict miss brings back the written-back line.
        wb_before = wb_cycles;
        do_access(0, 32'h0000_0104, 32'd0, 0, 1);
        chk("clean_no_wb", wb_cycles, wb_before);
        chk("clean_data", {224'd0, last_data}, {224'd0, 32'hDEAD_BEEF});

        // Zero-wait memory on a dirty miss.
        do_access(1, 32'h0000_0104, 32'hCAFE_F00D, 0, 0);
        do_access(0, 32'h0000_0504, 32'd0, 0, 0);
        chk("zero_wait_stall_len", last_run, 4);

        // Reset during ALLOCATE, with an ack arriving in the reset cycle.
        bus.p1_req_i   = 1'b1;
        bus.p1_write_i = 1'b0;
        bus.p1_addr_i  = 32'h0000_0904;
        exp_q.push_back(pack(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0));
        tick();
        bus.mem_data_i = mem_line(32'h900);
        repeat (2) begin
            exp_q.push_back(pack(1'b1, 32'd0, 1'b1, 1'b0, 32'h900, 256'd0));
            tick();
        end
        rst           = 1'b1;
        bus.mem_ack_i = 1'b1;
        exp_q.push_back(pack(1'b1, 32'd0, 1'b1, 1'b0, 32'h900, 256'd0));
        tick();
        rst           = 1'b0;
        bus.mem_ack_i = 1'b0;
        bus.p1_req_i  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        chk("midrst_state",  {254'd0, fsm_state}, 256'd0);
        chk("midrst_mem_en", {255'd0, bus.mem_enable_o}, 256'd0);
        exp_q.push_back(pack(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 256'd0));
        tick();
        do_access(0, 32'h0000_0504, 32'd0, 0, 1);
        chk("midrst_remiss_len", last_run, 4);

        // Random accesses over a few tags and indices to force conflicts.
        for (int n = 0; n < 200; n++) begin
            ra = $urandom_range(0, 3) * 1024 + $urandom_range(0, 3) * 32
               + $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
            do_access(1'($urandom_range(0, 1)), ra, $urandom(),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
